// File: rtl/pipe_stage_skid_pkg.sv
// Shared pipeline definitions: default bundle widths, occupancy state encodings,
// and control-bundle bit positions used when stages pack/unpack ctrl.
package pipe_stage_skid_pkg;

  localparam int DEF_DWIDTH = 32;
  localparam int DEF_CWIDTH = 8;

  // Encoding is {skid_valid, main_valid}; 2'b10 is unreachable.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'b00,
    OCC_FULL  = 2'b01,
    OCC_SKID  = 2'b11
  } occ_state_e;

  localparam int CTRL_REGWR  = 0;
  localparam int CTRL_MEMWR  = 1;
  localparam int CTRL_MEMRD  = 2;
  localparam int CTRL_BRANCH = 3;
  localparam int CTRL_JUMP   = 4;
  localparam int CTRL_WB_SEL = 5;

  function automatic occ_state_e occ_state(input logic skid_v, input logic main_v);
    return occ_state_e'({skid_v, main_v});
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One pipeline entry: valid bit plus ctrl/data payload. Clear wins over load and
// only touches the valid bit; payload changes only when an entry is loaded.
module pipe_slot #(
  parameter int CWIDTH = 8,
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic              i_clr,
  input  logic [CWIDTH-1:0] i_ctrl,
  input  logic [DWIDTH-1:0] i_data,
  output logic              o_valid,
  output logic [CWIDTH-1:0] o_ctrl,
  output logic [DWIDTH-1:0] o_data
);

  logic              r_valid;
  logic [CWIDTH-1:0] r_ctrl;
  logic [DWIDTH-1:0] r_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
      r_data  <= '0;
    end else if (i_clr) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_ctrl  <= i_ctrl;
      r_data  <= i_data;
    end
  end

  assign o_valid = r_valid;
  assign o_ctrl  = r_ctrl;
  assign o_data  = r_data;

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake and a one-deep skid slot,
// so in_ready is a pure register output and stalls never form a combinational path.
module pipe_stage_skid
  import pipe_stage_skid_pkg::*;
#(
  parameter int DWIDTH               = DEF_DWIDTH,
  parameter int CWIDTH               = DEF_CWIDTH,
  parameter int CTRL_ZERO_ON_INVALID = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CWIDTH-1:0] in_ctrl,
  input  logic [DWIDTH-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CWIDTH-1:0] out_ctrl,
  output logic [DWIDTH-1:0] out_data,
  output logic [1:0]        occupancy
);

  logic              w_main_valid, w_skid_valid;
  logic [CWIDTH-1:0] w_main_ctrl, w_skid_ctrl, w_main_in_ctrl;
  logic [DWIDTH-1:0] w_main_data, w_skid_data, w_main_in_data;
  logic              w_acc_in, w_acc_out;
  logic              w_main_load, w_main_clr, w_skid_load, w_skid_clr;
  occ_state_e        w_state;

  assign w_state   = occ_state(w_skid_valid, w_main_valid);
  assign in_ready  = !w_skid_valid;
  assign w_acc_in  = in_valid && in_ready;
  assign w_acc_out = w_main_valid && out_ready;

  always_comb begin
    w_main_load = 1'b0;
    w_main_clr  = 1'b0;
    w_skid_load = 1'b0;
    w_skid_clr  = 1'b0;
    if (flush) begin
      w_main_clr = 1'b1;
      w_skid_clr = 1'b1;
    end else begin
      case (w_state)
        OCC_EMPTY: w_main_load = w_acc_in;
        OCC_FULL: begin
          if (w_acc_out && w_acc_in) w_main_load = 1'b1;
          else if (w_acc_out)        w_main_clr  = 1'b1;
          else if (w_acc_in)         w_skid_load = 1'b1;
        end
        OCC_SKID: begin
          w_main_load = w_acc_out;
          w_skid_clr  = w_acc_out;
        end
        default: begin
          // Unreachable encoding; fall back to EMPTY rather than wedge.
          w_main_clr = 1'b1;
          w_skid_clr = 1'b1;
        end
      endcase
    end
  end

  // The skid entry is older than anything upstream, so it refills main first.
  assign w_main_in_ctrl = w_skid_valid ? w_skid_ctrl : in_ctrl;
  assign w_main_in_data = w_skid_valid ? w_skid_data : in_data;

  pipe_slot #(.CWIDTH(CWIDTH), .DWIDTH(DWIDTH)) u_main (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_main_load),
    .i_clr   (w_main_clr),
    .i_ctrl  (w_main_in_ctrl),
    .i_data  (w_main_in_data),
    .o_valid (w_main_valid),
    .o_ctrl  (w_main_ctrl),
    .o_data  (w_main_data)
  );

  pipe_slot #(.CWIDTH(CWIDTH), .DWIDTH(DWIDTH)) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_skid_load),
    .i_clr   (w_skid_clr),
    .i_ctrl  (in_ctrl),
    .i_data  (in_data),
    .o_valid (w_skid_valid),
    .o_ctrl  (w_skid_ctrl),
    .o_data  (w_skid_data)
  );

  generate
    if (CTRL_ZERO_ON_INVALID != 0) begin : g_ctrl_bubble_nop
      assign out_ctrl = w_main_valid ? w_main_ctrl : '0;
    end else begin : g_ctrl_pass
      assign out_ctrl = w_main_ctrl;
    end
  endgenerate

  assign out_valid = w_main_valid;
  assign out_data  = w_main_data;
  assign occupancy = {1'b0, w_main_valid} + {1'b0, w_skid_valid};

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed scenarios plus a random run against a queue
// model; a second instance with CTRL_ZERO_ON_INVALID=0 shows stale ctrl on bubbles.
module tb_pipe_stage_skid;

  localparam int DW = 32;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic [CW-1:0] in_ctrl = '0;
  logic [DW-1:0] in_data = '0;
  logic          out_ready = 1'b0;

  logic          in_ready0, out_valid0, in_ready1, out_valid1;
  logic [CW-1:0] out_ctrl0, out_ctrl1;
  logic [DW-1:0] out_data0, out_data1;
  logic [1:0]    occ0, occ1;

  always #5 clk = ~clk;

  pipe_stage_skid #(.DWIDTH(DW), .CWIDTH(CW), .CTRL_ZERO_ON_INVALID(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready0), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid0), .out_ready(out_ready), .out_ctrl(out_ctrl0), .out_data(out_data0),
    .occupancy(occ0)
  );

  pipe_stage_skid #(.DWIDTH(DW), .CWIDTH(CW), .CTRL_ZERO_ON_INVALID(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready1), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid1), .out_ready(out_ready), .out_ctrl(out_ctrl1), .out_data(out_data1),
    .occupancy(occ1)
  );

  // Reference model: FIFO of {ctrl,data} entries held by the stage, at most two.
  logic [CW+DW-1:0] q[$];
  logic [DW-1:0]    hs_log[$];
  logic [CW-1:0]    last_ctrl = '0;
  logic [DW-1:0]    last_data = '0;
  int n_pass = 0;
  int n_total = 0;

  task automatic drive(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                       input logic ordy, input logic fl);
    @(negedge clk);
    in_valid = v; in_ctrl = c; in_data = d; out_ready = ordy; flush = fl;
  endtask

  // Advance one clock edge and update the model from the rules: room for a new
  // entry while fewer than two are held, head leaves on ready, flush empties all.
  task automatic tick();
    bit acc_in, acc_out;
    acc_in  = in_valid && (q.size() < 2);
    acc_out = (q.size() > 0) && out_ready;
    if (out_valid0 && out_ready) hs_log.push_back(out_data0);
    @(posedge clk);
    #1;
    if (flush) q.delete();
    else begin
      if (acc_out) void'(q.pop_front());
      if (acc_in) q.push_back({in_ctrl, in_data});
    end
    if (q.size() > 0) begin
      last_ctrl = q[0][CW+DW-1:DW];
      last_data = q[0][DW-1:0];
    end
  endtask

  task automatic model_reset();
    q.delete();
    hs_log.delete();
    last_ctrl = '0;
    last_data = '0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 8'h01, 32'h0000_00E1, 1'b0, 1'b0); tick();
    drive(1'b1, 8'h02, 32'h0000_00E2, 1'b0, 1'b0); tick();
    @(negedge clk);
    in_valid = 1'b1; in_ctrl = 8'h33; in_data = 32'h0000_00C0;
    #2 rst_n = 1'b0;
    #1;
    n_total++; if (out_valid0 !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", out_valid0); else n_pass++;
    n_total++; if (out_ctrl0 !== 8'h00) $display("FAIL reset_out_ctrl got %h exp 00", out_ctrl0); else n_pass++;
    n_total++; if (out_data0 !== 32'h0) $display("FAIL reset_out_data got %h exp 0", out_data0); else n_pass++;
    n_total++; if (in_ready0 !== 1'b1) $display("FAIL reset_in_ready got %b exp 1", in_ready0); else n_pass++;
    n_total++; if (occ0 !== 2'd0) $display("FAIL reset_occupancy got %0d exp 0", occ0); else n_pass++;
    n_total++; if (out_ctrl1 !== 8'h00) $display("FAIL reset_out_ctrl_nozero got %h exp 00", out_ctrl1); else n_pass++;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_total++; if (out_valid0 !== 1'b1) $display("FAIL post_reset_accept got %b exp 1", out_valid0); else n_pass++;
    n_total++; if (out_data0 !== 32'h0000_00C0) $display("FAIL post_reset_data got %h exp c0", out_data0); else n_pass++;
    n_total++; if (occ0 !== 2'd1) $display("FAIL post_reset_occ got %0d exp 1", occ0); else n_pass++;
    drive(1'b0, 8'h00, 32'h0, 1'b1, 1'b0); tick();
    $display("reset: async clear and first edge after release accepted 0x%h", 32'hC0);
  endtask

  task automatic test_streaming();
    logic [DW-1:0] vals [3];
    vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'h10 + 8'(i), vals[i], 1'b1, 1'b0);
      #1;
      n_total++; if (in_ready0 !== 1'b1) $display("FAIL stream_in_ready[%0d] got %b exp 1", i, in_ready0); else n_pass++;
      tick();
      n_total++; if (out_data0 !== vals[i]) $display("FAIL stream_data[%0d] got %h exp %h", i, out_data0, vals[i]); else n_pass++;
      n_total++; if (occ0 !== 2'd1) $display("FAIL stream_occ[%0d] got %0d exp 1", i, occ0); else n_pass++;
      $display("stream: sent 0x%h, out_data 0x%h occ %0d", vals[i], out_data0, occ0);
    end
    drive(1'b0, 8'h00, 32'h0, 1'b1, 1'b0); tick();
    n_total++; if (out_valid0 !== 1'b0) $display("FAIL stream_drain got %b exp 0", out_valid0); else n_pass++;
  endtask

  task automatic test_backpressure();
    hs_log.delete();
    drive(1'b1, 8'h01, 32'hA1, 1'b0, 1'b0); tick();
    drive(1'b1, 8'h02, 32'hA2, 1'b0, 1'b0); tick();
    n_total++; if (occ0 !== 2'd2) $display("FAIL bp_occ_full got %0d exp 2", occ0); else n_pass++;
    n_total++; if (in_ready0 !== 1'b0) $display("FAIL bp_in_ready got %b exp 0", in_ready0); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'h03, 32'hA3, 1'b0, 1'b0); tick();
      n_total++; if (occ0 !== 2'd2) $display("FAIL bp_hold_occ[%0d] got %0d exp 2", i, occ0); else n_pass++;
      n_total++; if (out_data0 !== 32'hA1) $display("FAIL bp_hold_head[%0d] got %h exp a1", i, out_data0); else n_pass++;
    end
    drive(1'b1, 8'h03, 32'hA3, 1'b1, 1'b0); tick();
    drive(1'b1, 8'h03, 32'hA3, 1'b1, 1'b0); tick();
    drive(1'b0, 8'h00, 32'h0, 1'b1, 1'b0); tick();
    n_total++; if (hs_log.size() != 3) $display("FAIL bp_count got %0d exp 3", hs_log.size()); else n_pass++;
    if (hs_log.size() == 3) begin
      n_total++; if (hs_log[0] !== 32'hA1) $display("FAIL bp_order0 got %h exp a1", hs_log[0]); else n_pass++;
      n_total++; if (hs_log[1] !== 32'hA2) $display("FAIL bp_order1 got %h exp a2", hs_log[1]); else n_pass++;
      n_total++; if (hs_log[2] !== 32'hA3) $display("FAIL bp_order2 got %h exp a3", hs_log[2]); else n_pass++;
    end
    n_total++; if (occ0 !== 2'd0) $display("FAIL bp_final_occ got %0d exp 0", occ0); else n_pass++;
    $display("backpressure: %0d entries drained in order", hs_log.size());
  endtask

  task automatic test_flush();
    drive(1'b1, 8'hB1, 32'hB1, 1'b0, 1'b0); tick();
    drive(1'b1, 8'hB2, 32'hB2, 1'b0, 1'b0); tick();
    n_total++; if (occ0 !== 2'd2) $display("FAIL flush_pre_occ got %0d exp 2", occ0); else n_pass++;
    drive(1'b1, 8'hB3, 32'hB3, 1'b0, 1'b1); tick();
    n_total++; if (out_valid0 !== 1'b0) $display("FAIL flush_out_valid got %b exp 0", out_valid0); else n_pass++;
    n_total++; if (occ0 !== 2'd0) $display("FAIL flush_occ got %0d exp 0", occ0); else n_pass++;
    n_total++; if (out_ctrl0 !== 8'h00) $display("FAIL flush_out_ctrl got %h exp 00", out_ctrl0); else n_pass++;
    n_total++; if (in_ready0 !== 1'b1) $display("FAIL flush_in_ready got %b exp 1", in_ready0); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 8'h00, 32'h0, 1'b1, 1'b0); tick();
      n_total++; if (out_valid0 !== 1'b0) $display("FAIL flush_no_b3[%0d] got %b exp 0", i, out_valid0); else n_pass++;
    end
    $display("flush: stage empty after flush, occ %0d", occ0);
  endtask

  task automatic test_bubble();
    drive(1'b1, 8'h5A, 32'h0000_5A5A, 1'b1, 1'b0); tick();
    drive(1'b0, 8'hFF, 32'hFFFF_FFFF, 1'b1, 1'b0); tick();
    drive(1'b0, 8'hFF, 32'hFFFF_FFFF, 1'b0, 1'b0); tick();
    n_total++; if (out_ctrl0 !== 8'h00) $display("FAIL bubble_zero got %h exp 00", out_ctrl0); else n_pass++;
    n_total++; if (out_ctrl1 !== 8'h5A) $display("FAIL bubble_stale got %h exp 5a", out_ctrl1); else n_pass++;
    n_total++; if (out_valid1 !== 1'b0) $display("FAIL bubble_valid got %b exp 0", out_valid1); else n_pass++;
    $display("bubble: out_ctrl zeroed=0x%h stale=0x%h", out_ctrl0, out_ctrl1);
  endtask

  task automatic test_random();
    int errs_before;
    logic ir_a, ir_b;
    errs_before = n_total - n_pass;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      drive($urandom_range(0, 99) < 70, 8'($urandom), $urandom,
            $urandom_range(0, 99) < 60, $urandom_range(0, 99) < 3);
      #1;
      ir_a = in_ready0;
      out_ready = ~out_ready;
      #1;
      ir_b = in_ready0;
      out_ready = ~out_ready;
      #1;
      n_total++; if (ir_a !== (q.size() < 2)) $display("FAIL rnd_in_ready c%0d got %b exp %b", cyc, ir_a, q.size() < 2); else n_pass++;
      n_total++; if (ir_b !== ir_a) $display("FAIL rnd_ready_path c%0d got %b exp %b", cyc, ir_b, ir_a); else n_pass++;
      n_total++; if (in_ready1 !== ir_a) $display("FAIL rnd_in_ready1 c%0d got %b exp %b", cyc, in_ready1, ir_a); else n_pass++;
      tick();
      n_total++; if (out_valid0 !== (q.size() > 0)) $display("FAIL rnd_out_valid c%0d got %b exp %b", cyc, out_valid0, q.size() > 0); else n_pass++;
      n_total++; if (occ0 !== 2'(q.size())) $display("FAIL rnd_occ c%0d got %0d exp %0d", cyc, occ0, q.size()); else n_pass++;
      n_total++; if (occ1 !== 2'(q.size())) $display("FAIL rnd_occ1 c%0d got %0d exp %0d", cyc, occ1, q.size()); else n_pass++;
      n_total++; if (out_data0 !== last_data) $display("FAIL rnd_data c%0d got %h exp %h", cyc, out_data0, last_data); else n_pass++;
      n_total++; if (out_ctrl0 !== ((q.size() > 0) ? last_ctrl : 8'h00)) $display("FAIL rnd_ctrl c%0d got %h exp %h", cyc, out_ctrl0, (q.size() > 0) ? last_ctrl : 8'h00); else n_pass++;
      n_total++; if (out_ctrl1 !== last_ctrl) $display("FAIL rnd_ctrl1 c%0d got %h exp %h", cyc, out_ctrl1, last_ctrl); else n_pass++;
      n_total++; if (out_data1 !== last_data) $display("FAIL rnd_data1 c%0d got %h exp %h", cyc, out_data1, last_data); else n_pass++;
      n_total++; if (out_valid1 !== out_valid0) $display("FAIL rnd_valid1 c%0d got %b exp %b", cyc, out_valid1, out_valid0); else n_pass++;
    end
    $display("random: 10000 cycles, %0d new failures", (n_total - n_pass) - errs_before);
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_bubble();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
